// File: rtl/audio_seq_pkg.sv
// -----------------------------------------------------------------------------
// audio_seq_pkg
// Shared types and constants for the audio filter sequencer.
//   state_e              : sequencer FSM states
//   MIN_RD_TO_WR_LATENCY : cycles from a codec read strobe to the earliest
//                          codec write strobe for the same sample
// -----------------------------------------------------------------------------
package audio_seq_pkg;

  typedef enum logic [2:0] {
    S_WARMUP  = 3'd0,
    S_IDLE    = 3'd1,
    S_FILTER  = 3'd2,
    S_LATCH   = 3'd3,
    S_WAIT_WR = 3'd4
  } state_e;

  localparam int unsigned MIN_RD_TO_WR_LATENCY = 3;

endpackage

// File: rtl/timeout_counter.sv
// -----------------------------------------------------------------------------
// timeout_counter
// Up-counter with synchronous clear and a terminal-count flag at LIMIT-1.
// The count holds at LIMIT-1 once reached, so tc_o stays high until cleared.
//   clk_i    : clock
//   reset_i  : synchronous active-high reset, count -> 0
//   clear_i  : synchronous clear, count -> 0 (wins over enable_i)
//   enable_i : advance the count by one
//   tc_o     : high while count == LIMIT-1
// -----------------------------------------------------------------------------
module timeout_counter #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tc_o = (count_q == CW'(LIMIT - 1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !tc_o) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/audio_filter_sequencer.sv
// -----------------------------------------------------------------------------
// audio_filter_sequencer
// Moves one stereo sample at a time from the codec, through the external
// left/right averaging filters, and back to the codec.
//
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   bypass                          : 1 = write raw sample, 0 = filter output
//   read_ready / read               : codec input handshake
//   readdata_left/right             : codec input samples
//   write_ready / write             : codec output handshake
//   writedata_left/right            : codec output samples (registered)
//   filt_enable                     : one-cycle enable to both filters
//   filt_in_left/right              : filter data_in (the captured sample)
//   filt_out_left/right             : filter data_out
//   busy                            : high whenever the FSM is not in S_IDLE
//   drop_count                      : saturating count of timed-out writes
//   state_dbg                       : current FSM state, for observation
//
// Handshake: a transfer happens in any cycle where the strobe and its ready
// are both high. read is only raised in S_IDLE (read = read_ready there), and
// write is only raised in S_WAIT_WR (write = write_ready there); both are
// combinational, so each transfer strobes for exactly one cycle. read_ready
// seen in any other state is left for a later S_IDLE.
// -----------------------------------------------------------------------------
module audio_filter_sequencer
  import audio_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned WR_TIMEOUT = 1024,
  parameter int unsigned DROP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bypass,
  input  logic                  read_ready,
  input  logic                  write_ready,
  input  logic [DATA_WIDTH-1:0] readdata_left,
  input  logic [DATA_WIDTH-1:0] readdata_right,
  output logic                  read,
  output logic                  write,
  output logic [DATA_WIDTH-1:0] writedata_left,
  output logic [DATA_WIDTH-1:0] writedata_right,
  output logic                  filt_enable,
  output logic [DATA_WIDTH-1:0] filt_in_left,
  output logic [DATA_WIDTH-1:0] filt_in_right,
  input  logic [DATA_WIDTH-1:0] filt_out_left,
  input  logic [DATA_WIDTH-1:0] filt_out_right,
  output logic                  busy,
  output logic [DROP_WIDTH-1:0] drop_count,
  output state_e                state_dbg
);

  state_e                state_q;
  state_e                state_d;

  logic [DATA_WIDTH-1:0] cap_left_q;
  logic [DATA_WIDTH-1:0] cap_right_q;
  logic                  bypass_q;
  logic [DATA_WIDTH-1:0] wd_left_q;
  logic [DATA_WIDTH-1:0] wd_right_q;
  logic [DROP_WIDTH-1:0] drop_q;

  logic                  tmo_clear;
  logic                  tmo_enable;
  logic                  tmo_tc;
  logic                  drop_event;
  logic                  latch_out;

  // ---------------------------------------------------------------------------
  // Write timeout: cleared on the S_LATCH edge so the first S_WAIT_WR cycle
  // sees 0; terminal count means WR_TIMEOUT cycles have been spent waiting.
  // ---------------------------------------------------------------------------
  timeout_counter #(
    .LIMIT(WR_TIMEOUT)
  ) u_wr_timeout (
    .clk_i    (clk),
    .reset_i  (reset),
    .clear_i  (tmo_clear),
    .enable_i (tmo_enable),
    .tc_o     (tmo_tc)
  );

  // ---------------------------------------------------------------------------
  // Next-state and strobe logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    read        = 1'b0;
    write       = 1'b0;
    filt_enable = 1'b0;
    tmo_clear   = 1'b0;
    tmo_enable  = 1'b0;
    drop_event  = 1'b0;
    latch_out   = 1'b0;
    case (state_q)
      // Filters ignore enable in their first cycle out of reset.
      S_WARMUP: begin
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (read_ready) begin
          read    = 1'b1;
          state_d = S_FILTER;
        end
      end
      // Filters run in bypass mode too so their window stays continuous.
      S_FILTER: begin
        filt_enable = 1'b1;
        state_d     = S_LATCH;
      end
      S_LATCH: begin
        latch_out = 1'b1;
        tmo_clear = 1'b1;
        state_d   = S_WAIT_WR;
      end
      S_WAIT_WR: begin
        write = write_ready;
        if (write_ready) begin
          // A write on the terminal-count cycle wins over the drop.
          state_d = S_IDLE;
        end else if (tmo_tc) begin
          drop_event = 1'b1;
          state_d    = S_IDLE;
        end else begin
          tmo_enable = 1'b1;
        end
      end
      default: begin
        state_d = S_WARMUP;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_WARMUP;
      cap_left_q  <= '0;
      cap_right_q <= '0;
      bypass_q    <= 1'b0;
      wd_left_q   <= '0;
      wd_right_q  <= '0;
      drop_q      <= '0;
    end else begin
      state_q <= state_d;
      // bypass is captured with the sample so later changes do not affect it.
      if (read) begin
        cap_left_q  <= readdata_left;
        cap_right_q <= readdata_right;
        bypass_q    <= bypass;
      end
      if (latch_out) begin
        if (bypass_q) begin
          wd_left_q  <= cap_left_q;
          wd_right_q <= cap_right_q;
        end else begin
          wd_left_q  <= filt_out_left;
          wd_right_q <= filt_out_right;
        end
      end
      if (drop_event && (drop_q != {DROP_WIDTH{1'b1}})) begin
        drop_q <= drop_q + DROP_WIDTH'(1);
      end
    end
  end

  assign filt_in_left    = cap_left_q;
  assign filt_in_right   = cap_right_q;
  assign writedata_left  = wd_left_q;
  assign writedata_right = wd_right_q;
  assign drop_count      = drop_q;
  assign busy            = (state_q != S_IDLE);
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_audio_filter_sequencer.sv
// -----------------------------------------------------------------------------
// tb_audio_filter_sequencer
// Directed bench for audio_filter_sequencer with WR_TIMEOUT=8, DROP_WIDTH=2
// and a behavioural 4-tap moving-average filter pair on the filter ports.
// -----------------------------------------------------------------------------
module tb_audio_filter_sequencer;
  import audio_seq_pkg::*;

  localparam int DW  = 24;
  localparam int WRT = 8;
  localparam int DRW = 2;

  // --------------------------------------------------------------------------
  // Clock / reset / DUT
  // --------------------------------------------------------------------------
  logic                 clk;
  logic                 reset;
  logic                 bypass;
  logic                 read_ready;
  logic                 write_ready;
  logic signed [DW-1:0] rd_l, rd_r;
  logic                 read, write;
  logic signed [DW-1:0] wd_l, wd_r;
  logic                 filt_en;
  logic signed [DW-1:0] fin_l, fin_r;
  logic signed [DW-1:0] fout_l, fout_r;
  logic                 busy;
  logic [DRW-1:0]       drop_count;
  state_e               state_dbg;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  audio_filter_sequencer #(
    .DATA_WIDTH (DW),
    .WR_TIMEOUT (WRT),
    .DROP_WIDTH (DRW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .bypass          (bypass),
    .read_ready      (read_ready),
    .write_ready     (write_ready),
    .readdata_left   (rd_l),
    .readdata_right  (rd_r),
    .read            (read),
    .write           (write),
    .writedata_left  (wd_l),
    .writedata_right (wd_r),
    .filt_enable     (filt_en),
    .filt_in_left    (fin_l),
    .filt_in_right   (fin_r),
    .filt_out_left   (fout_l),
    .filt_out_right  (fout_r),
    .busy            (busy),
    .drop_count      (drop_count),
    .state_dbg       (state_dbg)
  );

  // --------------------------------------------------------------------------
  // External filter model: average of the newest input and three previous.
  // Ignores enable in the first cycle after reset, like the real filters.
  // --------------------------------------------------------------------------
  logic signed [DW-1:0] hl [3];
  logic signed [DW-1:0] hr [3];
  logic                 fwarm_q;

  function automatic logic signed [DW-1:0] avg4(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b,
                                                input logic signed [DW-1:0] c,
                                                input logic signed [DW-1:0] d);
    logic signed [DW+1:0] s;
    s = a;
    s = s + b;
    s = s + c;
    s = s + d;
    return s[DW+1:2];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        hl[i] <= '0;
        hr[i] <= '0;
      end
      fout_l  <= '0;
      fout_r  <= '0;
      fwarm_q <= 1'b1;
    end else begin
      fwarm_q <= 1'b0;
      if (filt_en && !fwarm_q) begin
        fout_l <= avg4(fin_l, hl[0], hl[1], hl[2]);
        fout_r <= avg4(fin_r, hr[0], hr[1], hr[2]);
        hl[2] <= hl[1]; hl[1] <= hl[0]; hl[0] <= fin_l;
        hr[2] <= hr[1]; hr[1] <= hr[0]; hr[0] <= fin_r;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks. All driving happens just after a negedge; outputs are
  // sampled #1 later, well away from the posedge.
  // --------------------------------------------------------------------------

  // One sample with write_ready held high. byp_late is applied to bypass in
  // the cycle after the read (S_FILTER).
  task automatic run_sample(input  logic signed [DW-1:0] l,
                            input  logic signed [DW-1:0] r,
                            input  logic                 byp,
                            input  logic                 byp_late,
                            output logic signed [DW-1:0] ow_l,
                            output logic signed [DW-1:0] ow_r,
                            output int                   lat,
                            output logic                 got_write);
    int n;
    int t_rd;
    rd_l = l; rd_r = r; bypass = byp;
    write_ready = 1'b1; read_ready = 1'b1;
    got_write = 1'b0; ow_l = '0; ow_r = '0; lat = -1;
    #1;
    n = 0;
    while (!read && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!read) return;
    t_rd = cyc;
    @(negedge clk);
    read_ready = 1'b0; bypass = byp_late; rd_l = '0; rd_r = '0;
    #1;
    n = 0;
    while (!write && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!write) return;
    got_write = 1'b1;
    lat  = cyc - t_rd;
    ow_l = wd_l;
    ow_r = wd_r;
    @(negedge clk);
  endtask

  // One sample with write_ready held low; if race is set, write_ready rises
  // on the last allowed wait cycle.
  task automatic run_timeout(input  logic                 race,
                             output int                   waits,
                             output logic                 wrote,
                             output logic signed [DW-1:0] ow_l);
    int n;
    rd_l = 24'sd400; rd_r = -24'sd400; bypass = 1'b0;
    write_ready = 1'b0; read_ready = 1'b1;
    waits = 0; wrote = 1'b0; ow_l = '0;
    #1;
    n = 0;
    while (!read && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk);
    read_ready = 1'b0;
    #1;
    n = 0;
    while (state_dbg != S_IDLE && n < 40) begin
      if (state_dbg == S_WAIT_WR) begin
        waits++;
        if (race && waits == WRT) begin
          write_ready = 1'b1;
          #1;
        end
        if (write) begin
          wrote = 1'b1;
          ow_l  = wd_l;
        end
      end
      @(negedge clk); #1; n++;
    end
    write_ready = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; bypass = 1'b0; read_ready = 1'b1; write_ready = 1'b1;
    rd_l = 24'sd400; rd_r = -24'sd400;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (state_dbg !== S_WARMUP) begin n_bad++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, S_WARMUP); end
    n_cmp++; if (read !== 1'b0) begin n_bad++; $display("FAIL reset_read: got %b expected 0", read); end
    n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL reset_write: got %b expected 0", write); end
    n_cmp++; if (filt_en !== 1'b0) begin n_bad++; $display("FAIL reset_filt_enable: got %b expected 0", filt_en); end
    n_cmp++; if (wd_l !== 24'sd0 || wd_r !== 24'sd0) begin n_bad++; $display("FAIL reset_writedata: got %0d/%0d expected 0/0", wd_l, wd_r); end
    n_cmp++; if (drop_count !== 2'd0) begin n_bad++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b expected 1", busy); end
  endtask

  task automatic test_warmup();
    reset = 1'b0;
    #1;
    n_cmp++; if (read !== 1'b0) begin n_bad++; $display("FAIL warmup_read_c1: got %b expected 0", read); end
    @(negedge clk); #1;
    n_cmp++; if (read !== 1'b1) begin n_bad++; $display("FAIL warmup_read_c2: got %b expected 1", read); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL warmup_busy_idle: got %b expected 0", busy); end
  endtask

  // Constant 400/-400 into a 4-tap average starting from zeros.
  task automatic test_filtered_stream();
    logic signed [DW-1:0] exp_l [5] = '{24'sd100, 24'sd200, 24'sd300, 24'sd400, 24'sd400};
    logic signed [DW-1:0] ol, orr;
    int   lat;
    logic gw;
    for (int i = 0; i < 5; i++) begin
      run_sample(24'sd400, -24'sd400, 1'b0, 1'b0, ol, orr, lat, gw);
      n_cmp++; if (gw !== 1'b1 || ol !== exp_l[i]) begin n_bad++; $display("FAIL stream_left[%0d]: got %0d (write=%b) expected %0d", i, ol, gw, exp_l[i]); end
      n_cmp++; if (orr !== -exp_l[i]) begin n_bad++; $display("FAIL stream_right[%0d]: got %0d expected %0d", i, orr, -exp_l[i]); end
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL stream_latency[%0d]: got %0d expected 3", i, lat); end
    end
  endtask

  // Window before: 400,400,400,400. Bypassed 1236 enters the window, so the
  // next filtered sample is (400+1236+400+400)/4 = 609.
  task automatic test_bypass();
    logic signed [DW-1:0] ol, orr;
    int   lat;
    logic gw;
    run_sample(24'sd1236, -24'sd1236, 1'b1, 1'b0, ol, orr, lat, gw);
    n_cmp++; if (gw !== 1'b1 || ol !== 24'sd1236) begin n_bad++; $display("FAIL bypass_left: got %0d (write=%b) expected 1236", ol, gw); end
    n_cmp++; if (orr !== -24'sd1236) begin n_bad++; $display("FAIL bypass_right: got %0d expected -1236", orr); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL bypass_latency: got %0d expected 3", lat); end
    run_sample(24'sd400, -24'sd400, 1'b0, 1'b0, ol, orr, lat, gw);
    n_cmp++; if (gw !== 1'b1 || ol !== 24'sd609) begin n_bad++; $display("FAIL after_bypass_left: got %0d (write=%b) expected 609", ol, gw); end
    n_cmp++; if (orr !== -24'sd609) begin n_bad++; $display("FAIL after_bypass_right: got %0d expected -609", orr); end
  endtask

  // Four drops: 1, 2, 3, then saturation holds at 3 for a 2-bit counter.
  task automatic test_timeout();
    int   waits;
    logic wrote;
    logic signed [DW-1:0] ol;
    logic [DRW-1:0] exp_drop [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    for (int i = 0; i < 4; i++) begin
      run_timeout(1'b0, waits, wrote, ol);
      n_cmp++; if (waits !== WRT) begin n_bad++; $display("FAIL timeout_wait_cycles[%0d]: got %0d expected %0d", i, waits, WRT); end
      n_cmp++; if (wrote !== 1'b0) begin n_bad++; $display("FAIL timeout_no_write[%0d]: got %b expected 0", i, wrote); end
      n_cmp++; if (drop_count !== exp_drop[i]) begin n_bad++; $display("FAIL timeout_drop_count[%0d]: got %0d expected %0d", i, drop_count, exp_drop[i]); end
    end
  endtask

  // Window is 400 everywhere by now, so the raced write carries 400.
  task automatic test_timeout_race();
    int   waits;
    logic wrote;
    logic signed [DW-1:0] ol;
    run_timeout(1'b1, waits, wrote, ol);
    n_cmp++; if (wrote !== 1'b1) begin n_bad++; $display("FAIL race_write: got %b expected 1", wrote); end
    n_cmp++; if (waits !== WRT) begin n_bad++; $display("FAIL race_wait_cycles: got %0d expected %0d", waits, WRT); end
    n_cmp++; if (ol !== 24'sd400) begin n_bad++; $display("FAIL race_writedata: got %0d expected 400", ol); end
    n_cmp++; if (drop_count !== 2'd3) begin n_bad++; $display("FAIL race_drop_count: got %0d expected 3", drop_count); end
  endtask

  // read_ready held high: reads are spaced by exactly four cycles.
  task automatic test_back_to_back();
    int t_rd [3];
    int nr;
    int n;
    rd_l = 24'sd400; rd_r = -24'sd400; bypass = 1'b0;
    write_ready = 1'b1; read_ready = 1'b1;
    t_rd = '{-100, -100, -100};
    nr = 0; n = 0;
    #1;
    while (nr < 3 && n < 40) begin
      if (read) begin
        t_rd[nr] = cyc;
        nr++;
      end
      if (nr < 3) begin
        @(negedge clk); #1; n++;
      end
    end
    @(negedge clk);
    read_ready = 1'b0;
    #1;
    n = 0;
    while (state_dbg != S_IDLE && n < 20) begin
      @(negedge clk); #1; n++;
    end
    n_cmp++; if (t_rd[1] - t_rd[0] !== 4) begin n_bad++; $display("FAIL b2b_spacing_0: got %0d expected 4", t_rd[1] - t_rd[0]); end
    n_cmp++; if (t_rd[2] - t_rd[1] !== 4) begin n_bad++; $display("FAIL b2b_spacing_1: got %0d expected 4", t_rd[2] - t_rd[1]); end
  endtask

  task automatic test_reset_in_wait();
    int   n;
    logic saw_write;
    rd_l = 24'sd400; rd_r = -24'sd400; bypass = 1'b0;
    write_ready = 1'b0; read_ready = 1'b1;
    saw_write = 1'b0;
    #1;
    n = 0;
    while (!read && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk);
    read_ready = 1'b0;
    #1;
    n = 0;
    while (state_dbg != S_WAIT_WR && n < 20) begin
      @(negedge clk); #1; n++;
    end
    n_cmp++; if (state_dbg !== S_WAIT_WR) begin n_bad++; $display("FAIL rst_wait_reached: got %0d expected %0d", state_dbg, S_WAIT_WR); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (write) saw_write = 1'b1;
      @(negedge clk);
    end
    #1;
    n_cmp++; if (saw_write !== 1'b0) begin n_bad++; $display("FAIL rst_wait_no_write: got %b expected 0", saw_write); end
    n_cmp++; if (drop_count !== 2'd0) begin n_bad++; $display("FAIL rst_wait_drop_count: got %0d expected 0", drop_count); end
    n_cmp++; if (wd_l !== 24'sd0 || wd_r !== 24'sd0) begin n_bad++; $display("FAIL rst_wait_writedata: got %0d/%0d expected 0/0", wd_l, wd_r); end
    reset = 1'b0;
    #1;
    n_cmp++; if (state_dbg !== S_WARMUP) begin n_bad++; $display("FAIL rst_wait_warmup: got %0d expected %0d", state_dbg, S_WARMUP); end
    @(negedge clk); #1;
    n_cmp++; if (state_dbg !== S_IDLE) begin n_bad++; $display("FAIL rst_wait_idle: got %0d expected %0d", state_dbg, S_IDLE); end
    n_cmp++; if (drop_count !== 2'd0) begin n_bad++; $display("FAIL rst_wait_drop_after: got %0d expected 0", drop_count); end
  endtask

  // --------------------------------------------------------------------------
  // Sequence and report
  // --------------------------------------------------------------------------
  initial begin
    reset = 1'b1; bypass = 1'b0; read_ready = 1'b0; write_ready = 1'b0;
    rd_l = '0; rd_r = '0;
    test_reset();
    test_warmup();
    test_filtered_stream();
    test_bypass();
    test_timeout();
    test_timeout_race();
    test_back_to_back();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
